csa_resolver: RTL

- Carry-propagate back end for the carry-save adder array in the signed serial-parallel multiplier.
- Takes a redundant (sum, carry) pair and produces the two's-complement or unsigned binary value sum + 2*carry.
- Works CHUNK bits per cycle, with a registered ripple carry between chunks, so the long carry chain stays off the critical path.
- Valid/ready handshake on both the input and output sides.

---
 rtl/spm_pkg.sv | 22 ++
 rtl/csa_resolver_chunk_adder.sv | 14 +
 rtl/csa_resolver.sv | 112 +++++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the signed serial-parallel multiplier datapath:
// default width, resolver state encoding and chunk geometry helpers.
package spm_pkg;

  localparam int SPM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Extended width: room for sum + 2*carry (two extra bits), rounded up to whole chunks.
  function automatic int calc_ew(input int width, input int chunk);
    return ((width + 2 + chunk - 1) / chunk) * chunk;
  endfunction

  function automatic int calc_nchunk(input int width, input int chunk);
    return calc_ew(width, chunk) / chunk;
  endfunction

endpackage

// File: rtl/csa_resolver_chunk_adder.sv
// CHUNK-bit ripple adder slice with carry-in and carry-out.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// Resolves a redundant (sum, carry) pair into sum + 2*carry, CHUNK bits per
// cycle with a registered carry between chunks; valid/ready on both sides.
module csa_resolver
  import spm_pkg::*;
#(
  parameter int WIDTH       = SPM_WIDTH,
  parameter int CHUNK       = 4,
  parameter int SIGNED_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result,
  output logic             busy
);

  localparam int EW     = calc_ew(WIDTH, CHUNK);
  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK + 1) : 1;
  localparam int RW     = WIDTH + 2;

  state_t          state_q, state_d;
  logic [EW-1:0]   a_q, b_q, acc_q;
  logic            c_q;
  logic [IDXW-1:0] idx_q;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic            c_nx;
  logic            accept, last;

  function automatic logic [EW-1:0] ext(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    if (SIGNED_MODE != 0) return EW'(sv);
    return {{(EW-WIDTH){1'b0}}, v};
  endfunction

  assign accept = in_valid && in_ready;
  assign last   = (idx_q == IDXW'(NCHUNK - 1));
  assign a_sl   = a_q[idx_q*CHUNK +: CHUNK];
  assign b_sl   = b_q[idx_q*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (c_q),
    .s    (s_sl),
    .cout (c_nx)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture on accept, then one chunk per BUSY cycle into the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      c_q   <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      a_q   <= ext(sum_in);
      b_q   <= ext(carry_in) << 1;
      c_q   <= 1'b0;
      idx_q <= '0;
    end else if (state_q == BUSY) begin
      acc_q[idx_q*CHUNK +: CHUNK] <= s_sl;
      c_q   <= c_nx;
      idx_q <= idx_q + 1'b1;
    end
  end

  assign result = acc_q[RW-1:0];

  // Padding bits above WIDTH+2 only exist to round up to whole chunks
  generate
    if (EW > RW) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^acc_q[EW-1:RW];
    end
  endgenerate

endmodule
